// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe_pkg
//  Description : Shared helpers for the elastic register pipeline. Provides
//                a constant ceil(log2) function and the occupancy-width
//                derivation that the FIFOs reuse.
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_pipe_pkg;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bits needed to count 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe_stage
//  Description : One elastic stage: a valid bit plus a data register. The
//                stage can load whenever it is empty or the stage after it
//                is draining, which lets bubbles collapse under stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe_stage #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Empty stage always accepts; a full one only if it drains this cycle.
    assign ready = !r_valid || next_ready;
    assign valid = r_valid;
    assign data  = r_data;

    // Valid bit: flush clears it regardless of any pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ready) begin
            r_valid <= prev_valid;
        end
    end

    // Data register: only ever loads from a valid predecessor, so the
    // output data stays put whenever nothing valid is moving in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= RESET_VALUE;
        end else if (ready && prev_valid) begin
            r_data <= prev_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe
//  Description : Parametrised elastic register pipeline of DEPTH stages with
//                valid/ready flow control, collapsing bubbles, synchronous
//                flush and a combinational occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               OCC_W       = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [OCC_W-1:0] w_occ;

    // Stage 0 faces the input, stage DEPTH-1 faces the output. The ready
    // chain is kept as one scalar per stage so it runs purely combinationally
    // from out_ready back to the input.
    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            logic             w_ready;
            logic             w_next_ready;
            logic             w_prev_valid;
            logic [WIDTH-1:0] w_prev_data;

            if (s == 0) begin : g_head
                // Flushed input words never enter the pipe.
                assign w_prev_valid = in_valid && !flush;
                assign w_prev_data  = in_data;
            end else begin : g_body
                assign w_prev_valid = w_valid[s-1];
                assign w_prev_data  = w_data[s-1];
            end

            if (s == DEPTH - 1) begin : g_tail
                assign w_next_ready = out_ready;
            end else begin : g_inner
                assign w_next_ready = g_stage[s+1].w_ready;
            end

            dff_pipe_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .prev_valid (w_prev_valid),
                .prev_data  (w_prev_data),
                .next_ready (w_next_ready),
                .ready      (w_ready),
                .valid      (w_valid[s]),
                .data       (w_data[s])
            );
        end
    endgenerate

    // Popcount of the stage valid bits.
    always_comb begin
        w_occ = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_occ = w_occ + OCC_W'(w_valid[s]);
        end
    end

    assign in_ready  = g_stage[0].w_ready && !flush;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign occupancy = w_occ;

endmodule
`default_nettype wire
